feature_map_collector_16channel: RTL and testbench

FEATURE_MAP_COLLECTOR_16CHANNEL -- requirements
Module: feature_map_collector_16channel

---
 rtl/feature_map_collector_16channel.sv | 107 ++++++++++
 tb/tb_feature_map_collector_16channel.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/feature_map_collector_16channel.sv
// Single-frame buffer for a 16-channel feature map: captures one raster frame,
// then drains it in write order under ready/valid backpressure.
module feature_map_collector_16channel #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDHT*16-1:0] Data_In,
  input  logic                     Valid_In,
  input  logic                     Start_Read,
  input  logic                     Out_Ready,
  output logic [DATA_WIDHT*16-1:0] Data_Out,
  output logic                     Valid_Out,
  output logic                     Last_Out,
  output logic                     Frame_Done,
  output logic                     Overflow
);
  // state   | meaning
  // CAPTURE | writing Valid_In pixels into storage at wr_cnt
  // FULL    | complete frame held, waiting for Start_Read
  // DRAIN   | streaming stored frame out, addresses 0..N-1

  localparam int N  = IMG_WIDHT * IMG_HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = DATA_WIDHT * 16;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  typedef enum logic [1:0] {CAPTURE, FULL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic          rd_done, rd_valid, rd_last;
  logic [PW-1:0] rd_data;
  logic [PW-1:0] mem [N];
  logic          wr_en, xfer, load_out, issue;

  // Two-stage read pipeline (storage read register, then output register);
  // the read stage refills whenever the output stage is about to be freed.
  assign wr_en      = (state == CAPTURE) && Valid_In;
  assign xfer       = Valid_Out && Out_Ready;
  assign load_out   = rd_valid && (!Valid_Out || Out_Ready);
  assign issue      = (state == DRAIN) && !rd_done && (!rd_valid || load_out);
  assign Frame_Done = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CAPTURE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (Valid_In && wr_cnt == LAST_ADDR) state_nxt = FULL;
      FULL:    if (Start_Read) state_nxt = DRAIN;
      DRAIN:   if (xfer && Last_Out) state_nxt = CAPTURE;
      default: state_nxt = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_done   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      Data_Out  <= '0;
      Valid_Out <= 1'b0;
      Last_Out  <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      if (Valid_In && state != CAPTURE) Overflow <= 1'b1;

      if (wr_en) wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + 1'b1;

      if (state == FULL && Start_Read) begin
        rd_cnt  <= '0;
        rd_done <= 1'b0;
      end else if (issue) begin
        rd_cnt  <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
        rd_done <= (rd_cnt == LAST_ADDR);
        rd_last <= (rd_cnt == LAST_ADDR);
      end

      if (issue)         rd_valid <= 1'b1;
      else if (load_out) rd_valid <= 1'b0;

      if (load_out) begin
        Data_Out  <= rd_data;
        Valid_Out <= 1'b1;
        Last_Out  <= rd_last;
      end else if (xfer) begin
        Valid_Out <= 1'b0;
        Last_Out  <= 1'b0;
      end
    end
  end

  // Storage is never reset; rd_valid gating keeps stale contents from escaping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= Data_In;
    if (issue) rd_data <= mem[rd_cnt];
  end

endmodule

// File: tb/tb_feature_map_collector_16channel.sv
// Directed bench for feature_map_collector_16channel (4x4 frame, 32-bit channels)
// with a queue scoreboard of captured pixels popped on each output transfer.
module tb_feature_map_collector_16channel;
  localparam int DW   = 32;
  localparam int PW   = DW * 16;
  localparam int NPIX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] Data_In;
  logic          Valid_In;
  logic          Start_Read;
  logic          Out_Ready;
  logic [PW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Last_Out;
  logic          Frame_Done;
  logic          Overflow;

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] sb_q[$];

  always #5 clk = ~clk;

  feature_map_collector_16channel #(
    .DATA_WIDHT(DW), .IMG_WIDHT(4), .IMG_HEIGHT(4)
  ) dut (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
    .Start_Read(Start_Read), .Out_Ready(Out_Ready), .Data_Out(Data_Out),
    .Valid_Out(Valid_Out), .Last_Out(Last_Out), .Frame_Done(Frame_Done),
    .Overflow(Overflow)
  );

  function automatic logic [PW-1:0] pix(input int base, input int p);
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[DW*k +: DW] = DW'(base + 16*p + k);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input int base, input int sr_at);
    for (int p = 0; p < NPIX; p++) begin
      Valid_In   = 1'b1;
      Data_In    = pix(base, p);
      Start_Read = (p == sr_at);
      sb_q.push_back(pix(base, p));
      step();
      chk("cap_no_valid_out", Valid_Out, 0);
      chk("cap_frame_done", Frame_Done, (p == NPIX-1));
    end
    Valid_In   = 1'b0;
    Start_Read = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int stop_after, input bit inj);
    logic [PW-1:0] held, exp;
    bit stalled;
    int xfers, first_vld, last_edge;
    stalled = 0; xfers = 0; first_vld = -1; last_edge = -1; held = '0;
    Start_Read = 1'b1;
    step();
    Start_Read = 1'b0;
    chk("start_frame_done_clr", Frame_Done, 0);
    for (int e = 0; e < 200 && xfers < NPIX && xfers != stop_after; e++) begin
      Out_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_valid_hold", Valid_Out, 1);
        chk("stall_data_hold", Data_Out, held);
      end
      if (Valid_Out === 1'b1 && first_vld < 0) first_vld = e;
      if (Valid_Out === 1'b1 && Out_Ready) begin
        chk("sb_nonempty", (sb_q.size() > 0), 1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("drain_data", Data_Out, exp);
        chk("drain_last", Last_Out, (xfers == NPIX-1));
        if (xfers == NPIX-1) begin
          last_edge = e;
          if (inj) begin
            Valid_In = 1'b1;
            Data_In  = pix(999, 0);
          end
        end
        xfers++;
        stalled = 0;
      end else begin
        stalled = (Valid_Out === 1'b1);
      end
      held = Data_Out;
      step();
    end
    Valid_In = 1'b0;
    chk("first_valid_edge", first_vld, 2);
    if (stop_after < 0) begin
      chk("drain_count", xfers, NPIX);
      chk("drain_end_valid", Valid_Out, 0);
      chk("drain_end_last", Last_Out, 0);
      chk("drain_end_frame_done", Frame_Done, 0);
      if (!rnd) chk("drain_back_to_back", last_edge, 17);
    end
  endtask

  initial begin
    rst = 1'b1; Valid_In = 1'b0; Start_Read = 1'b0; Out_Ready = 1'b0; Data_In = '0;
    #12;
    chk("rst_valid_out", Valid_Out, 0);
    chk("rst_last_out", Last_Out, 0);
    chk("rst_frame_done", Frame_Done, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_data_out", Data_Out, 0);
    @(negedge clk);
    rst = 1'b0;

    // plain capture and full-rate drain
    capture(0, -1);
    drain(1'b0, -1, 1'b0);
    chk("no_overflow_yet", Overflow, 0);

    // Start_Read during capture is ignored and not remembered
    capture(1000, 8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_valid_out", Valid_Out, 0);
      chk("full_frame_done", Frame_Done, 1);
    end

    // writes while FULL are dropped and flag Overflow
    for (int i = 0; i < 3; i++) begin
      Valid_In = 1'b1;
      Data_In  = pix(500, i);
      step();
      Valid_In = 1'b0;
      step();
      chk("full_overflow_set", Overflow, 1);
      chk("full_overflow_frame_done", Frame_Done, 1);
    end
    drain(1'b1, -1, 1'b0);
    chk("overflow_sticky", Overflow, 1);

    // reset between edges in the middle of a drain
    capture(2000, -1);
    drain(1'b1, 5, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid_out", Valid_Out, 0);
    chk("midrst_last_out", Last_Out, 0);
    chk("midrst_frame_done", Frame_Done, 0);
    chk("midrst_overflow", Overflow, 0);
    chk("midrst_data_out", Data_Out, 0);
    #2 rst = 1'b0;
    sb_q.delete();

    // fresh frame right after reset; Valid_In on the returning edge is dropped
    capture(3000, -1);
    chk("post_rst_overflow", Overflow, 0);
    drain(1'b0, -1, 1'b1);
    chk("return_edge_overflow", Overflow, 1);
    capture(4000, -1);
    drain(1'b1, -1, 1'b0);
    chk("sb_empty_at_end", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
